// File: rtl/bus_master_port.sv
`default_nettype none
// =====================================================================
// bus_master_port : latches a command, wins the bus, then serialises
// header/write data or collects read words.            Rev 1.0
// =====================================================================
module bus_master_port #(
  parameter int SLAVE_LEN   = 2,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_LEN-1:0]  address,
  input  logic [DATA_LEN-1:0]  data,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic [SLAVE_LEN-1:0] slave_select_input,
  input  logic [1:0]           instruction,
  input  logic                 bus_grant,
  input  logic                 slave_ready,
  input  logic                 s_valid,
  input  logic                 s_din,
  output logic                 bus_req,
  output logic [SLAVE_LEN-1:0] slave_select,
  output logic                 m_valid,
  output logic                 m_dout,
  output logic                 tx_done,
  output logic                 new_rx,
  output logic                 rx_done,
  output logic [DATA_LEN-1:0]  new_data,
  output logic                 busy,
  output logic                 error
);

  localparam int c_HDR_LEN = 1 + ADDR_LEN + BURST_LEN;
  localparam int c_TX_LEN  = (c_HDR_LEN > DATA_LEN) ? c_HDR_LEN : DATA_LEN;
  localparam int c_MAX_CNT = (c_TX_LEN > ACK_TIMEOUT) ? c_TX_LEN : ACK_TIMEOUT;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam logic [c_CNT_W-1:0] c_HDR_LAST = c_CNT_W'(c_HDR_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(DATA_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_HEADER   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WRITE    = 3'd4,
    S_READ     = 3'd5
  } state_t;

  state_t               r_state, w_state_nx;
  logic                 r_instr_prev;
  logic                 r_rw, w_rw_nx;
  logic [SLAVE_LEN-1:0] r_slave, w_slave_nx;
  logic [DATA_LEN-1:0]  r_data, w_data_nx;
  logic [BURST_LEN-1:0] r_beats, w_beats_nx;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [c_TX_LEN-1:0]  r_tx, w_tx_nx;
  logic [DATA_LEN-1:0]  r_rx, w_rx_nx;
  logic [DATA_LEN-1:0]  r_new_data, w_new_data_nx;
  logic                 r_tx_done, w_tx_done_nx;
  logic                 r_new_rx, w_new_rx_nx;
  logic                 r_rx_done, w_rx_done_nx;
  logic                 r_error, w_error_nx;

  logic                 w_start;
  logic                 w_abort;
  logic                 w_beat_last;
  logic [BURST_LEN-1:0] w_beats_in;
  logic [c_HDR_LEN-1:0] w_header;
  logic [DATA_LEN-1:0]  w_rx_shift;

  assign w_start     = instruction[1] & ~r_instr_prev;
  assign w_beats_in  = (burst_num == '0) ? BURST_LEN'(1) : burst_num;
  assign w_header    = {w_beats_in, address, instruction[0]};
  assign w_beat_last = (r_beats == BURST_LEN'(1));
  // Read bits arrive LSB-first, so new bits enter at the MSB and move down.
  assign w_rx_shift  = DATA_LEN'({s_din, r_rx} >> 1);

  always_comb begin
    w_state_nx    = r_state;
    w_rw_nx       = r_rw;
    w_slave_nx    = r_slave;
    w_data_nx     = r_data;
    w_beats_nx    = r_beats;
    w_cnt_nx      = r_cnt;
    w_tx_nx       = r_tx;
    w_rx_nx       = r_rx;
    w_new_data_nx = r_new_data;
    w_tx_done_nx  = 1'b0;
    w_new_rx_nx   = 1'b0;
    w_rx_done_nx  = 1'b0;
    w_error_nx    = 1'b0;
    w_abort       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_rw_nx    = instruction[0];
          w_slave_nx = slave_select_input;
          w_data_nx  = data;
          w_beats_nx = w_beats_in;
          w_tx_nx    = c_TX_LEN'(w_header);
          w_cnt_nx   = '0;
          w_state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant) begin
          w_cnt_nx   = '0;
          w_state_nx = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!bus_grant) begin
          w_abort = 1'b1;
        end else if (r_cnt == c_HDR_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = S_WAIT_ACK;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          w_tx_nx  = r_tx >> 1;
        end
      end
      S_WAIT_ACK: begin
        if (!bus_grant) begin
          w_abort = 1'b1;
        end else if (slave_ready) begin
          w_cnt_nx = '0;
          if (r_rw) begin
            w_rx_nx    = '0;
            w_state_nx = S_READ;
          end else begin
            w_tx_nx    = c_TX_LEN'(r_data);
            w_state_nx = S_WRITE;
          end
        end else if (r_cnt == c_ACK_LAST) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_WRITE: begin
        // Completing the final bit takes priority over a grant drop.
        if ((r_cnt == c_BIT_LAST) && w_beat_last) begin
          w_tx_done_nx = 1'b1;
          w_state_nx   = S_IDLE;
        end else if (!bus_grant) begin
          w_abort = 1'b1;
        end else if (r_cnt == c_BIT_LAST) begin
          w_beats_nx = r_beats - BURST_LEN'(1);
          w_cnt_nx   = '0;
          w_tx_nx    = c_TX_LEN'(r_data);
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          w_tx_nx  = r_tx >> 1;
        end
      end
      S_READ: begin
        if (s_valid && (r_cnt == c_BIT_LAST) && w_beat_last) begin
          w_new_data_nx = w_rx_shift;
          w_new_rx_nx   = 1'b1;
          w_rx_done_nx  = 1'b1;
          w_state_nx    = S_IDLE;
        end else if (!bus_grant) begin
          w_abort = 1'b1;
        end else if (s_valid) begin
          w_rx_nx = w_rx_shift;
          if (r_cnt == c_BIT_LAST) begin
            w_new_data_nx = w_rx_shift;
            w_new_rx_nx   = 1'b1;
            w_beats_nx    = r_beats - BURST_LEN'(1);
            w_cnt_nx      = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_abort) begin
      w_error_nx = 1'b1;
      w_state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_instr_prev <= 1'b0;
      r_rw         <= 1'b0;
      r_slave      <= '0;
      r_data       <= '0;
      r_beats      <= '0;
      r_cnt        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_new_data   <= '0;
      r_tx_done    <= 1'b0;
      r_new_rx     <= 1'b0;
      r_rx_done    <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_instr_prev <= instruction[1];
      r_rw         <= w_rw_nx;
      r_slave      <= w_slave_nx;
      r_data       <= w_data_nx;
      r_beats      <= w_beats_nx;
      r_cnt        <= w_cnt_nx;
      r_tx         <= w_tx_nx;
      r_rx         <= w_rx_nx;
      r_new_data   <= w_new_data_nx;
      r_tx_done    <= w_tx_done_nx;
      r_new_rx     <= w_new_rx_nx;
      r_rx_done    <= w_rx_done_nx;
      r_error      <= w_error_nx;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign bus_req      = (r_state != S_IDLE);
  assign slave_select = ((r_state == S_IDLE) || (r_state == S_REQ)) ? '0 : r_slave;
  assign m_valid      = (r_state == S_HEADER) || (r_state == S_WRITE);
  assign m_dout       = m_valid & r_tx[0];
  assign tx_done      = r_tx_done;
  assign new_rx       = r_new_rx;
  assign rx_done      = r_rx_done;
  assign new_data     = r_new_data;
  assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// =====================================================================
// tb_bus_master_port : directed self-checking bench for bus_master_port.
// Rev 1.0
// =====================================================================
module tb_bus_master_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] address;
  logic [7:0]  data;
  logic [11:0] burst_num;
  logic [1:0]  slave_select_input;
  logic [1:0]  instruction;
  logic        bus_grant;
  logic        slave_ready;
  logic        s_valid;
  logic        s_din;
  logic        bus_req;
  logic [1:0]  slave_select;
  logic        m_valid;
  logic        m_dout;
  logic        tx_done;
  logic        new_rx;
  logic        rx_done;
  logic [7:0]  new_data;
  logic        busy;
  logic        error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_master_port dut (
    .clk(clk), .reset(reset), .address(address), .data(data),
    .burst_num(burst_num), .slave_select_input(slave_select_input),
    .instruction(instruction), .bus_grant(bus_grant), .slave_ready(slave_ready),
    .s_valid(s_valid), .s_din(s_din), .bus_req(bus_req), .slave_select(slave_select),
    .m_valid(m_valid), .m_dout(m_dout), .tx_done(tx_done), .new_rx(new_rx),
    .rx_done(rx_done), .new_data(new_data), .busy(busy), .error(error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch a command and walk it through REQ and HEADER, capturing the header bits.
  task automatic to_wait_ack(input logic [11:0] a, input logic [7:0] d, input logic [11:0] b,
                             input logic [1:0] s, input logic rd, output logic [24:0] hdr);
    instruction = 2'b00;
    tick();
    address = a; data = d; burst_num = b; slave_select_input = s;
    instruction = {1'b1, rd};
    tick();
    bus_grant = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      hdr[i] = m_dout;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; address = '0; data = '0; burst_num = '0; slave_select_input = '0;
    instruction = 2'b00; bus_grant = 1'b0; slave_ready = 1'b0; s_valid = 1'b0; s_din = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    checks++; if ({m_valid, m_dout} !== 2'b00) begin errors++; $display("FAIL reset_mdata: got %b want 00", {m_valid, m_dout}); end
    checks++; if ({tx_done, new_rx, rx_done, error} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {tx_done, new_rx, rx_done, error}); end
    checks++; if (new_data !== 8'h00) begin errors++; $display("FAIL reset_new_data: got %h want 00", new_data); end
    checks++; if (slave_select !== 2'd0) begin errors++; $display("FAIL reset_slave_select: got %0d want 0", slave_select); end
    reset = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write;
    logic [24:0] hobs;
    logic [7:0]  dobs;
    logic        vbad;
    vbad = 1'b0;
    slave_ready = 1'b1; bus_grant = 1'b0;
    address = 12'h0A5; data = 8'hC3; burst_num = 12'd0; slave_select_input = 2'd2;
    instruction = 2'b00;
    tick();
    instruction = 2'b10;
    tick();
    checks++; if ({bus_req, busy} !== 2'b11) begin errors++; $display("FAIL wr_req: got %b want 11", {bus_req, busy}); end
    tick(); tick();
    checks++; if ({bus_req, m_valid, slave_select} !== 4'b1000) begin errors++; $display("FAIL wr_wait_grant: got %b want 1000", {bus_req, m_valid, slave_select}); end
    bus_grant = 1'b1;
    tick();
    checks++; if (slave_select !== 2'd2) begin errors++; $display("FAIL wr_slave_select: got %0d want 2", slave_select); end
    for (int i = 0; i < 25; i++) begin
      hobs[i] = m_dout;
      if (m_valid !== 1'b1) vbad = 1'b1;
      tick();
    end
    checks++; if (hobs !== 25'h000214A) begin errors++; $display("FAIL wr_header: got %h want 000214a", hobs); end
    checks++; if ({m_valid, m_dout} !== 2'b00) begin errors++; $display("FAIL wr_wait_ack_idle_line: got %b want 00", {m_valid, m_dout}); end
    tick();
    for (int i = 0; i < 8; i++) begin
      dobs[i] = m_dout;
      if (m_valid !== 1'b1) vbad = 1'b1;
      tick();
    end
    checks++; if (dobs !== 8'hC3) begin errors++; $display("FAIL wr_data_bits: got %h want c3", dobs); end
    checks++; if (vbad !== 1'b0) begin errors++; $display("FAIL wr_m_valid_gap: got %b want 0", vbad); end
    checks++; if ({tx_done, error, bus_req, m_valid, slave_select} !== 6'b100000) begin errors++; $display("FAIL wr_done: got %b want 100000", {tx_done, error, bus_req, m_valid, slave_select}); end
    tick();
    checks++; if ({tx_done, busy} !== 2'b00) begin errors++; $display("FAIL wr_done_pulse: got %b want 00", {tx_done, busy}); end
  endtask

  task automatic test_burst_read;
    logic [24:0] hobs;
    logic [7:0]  words [3];
    int          pulses;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    pulses = 0;
    slave_ready = 1'b0;
    to_wait_ack(12'h123, 8'h00, 12'd3, 2'd1, 1'b1, hobs);
    checks++; if (hobs !== 25'h0006247) begin errors++; $display("FAIL rd_header: got %h want 0006247", hobs); end
    tick(); tick();
    checks++; if ({busy, m_valid} !== 2'b10) begin errors++; $display("FAIL rd_wait_ack: got %b want 10", {busy, m_valid}); end
    slave_ready = 1'b1;
    tick();
    slave_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        s_valid = 1'b1; s_din = words[w][i];
        tick();
        s_valid = 1'b0;
        if (new_rx === 1'b1) pulses++;
        if (w == 1 && i == 3) begin
          tick();
          if (new_rx === 1'b1) pulses++;
        end
      end
      checks++; if ({new_rx, rx_done, new_data} !== {1'b1, (w == 2), words[w]}) begin
        errors++; $display("FAIL rd_word%0d: got %b want %b", w, {new_rx, rx_done, new_data}, {1'b1, (w == 2), words[w]});
      end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL rd_new_rx_count: got %0d want 3", pulses); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rd_release: got %b want 0", bus_req); end
    tick();
    checks++; if ({rx_done, new_rx, new_data} !== {2'b00, 8'h33}) begin errors++; $display("FAIL rd_hold: got %b want 0000110011", {rx_done, new_rx, new_data}); end
  endtask

  task automatic test_timeout;
    logic [24:0] hobs;
    int k;
    slave_ready = 1'b0;
    to_wait_ack(12'h3FF, 8'hFF, 12'd0, 2'd3, 1'b0, hobs);
    for (k = 1; k <= 300; k++) begin
      tick();
      if (error === 1'b1) break;
    end
    checks++; if (k !== 255) begin errors++; $display("FAIL timeout_cycles: got %0d want 255", k); end
    checks++; if ({bus_req, busy, m_valid} !== 3'b000) begin errors++; $display("FAIL timeout_release: got %b want 000", {bus_req, busy, m_valid}); end
    tick();
    checks++; if ({error, busy} !== 2'b00) begin errors++; $display("FAIL timeout_pulse: got %b want 00", {error, busy}); end
  endtask

  task automatic test_grant_loss;
    logic [24:0] hobs;
    int done_cnt;
    done_cnt = 0;
    slave_ready = 1'b1;
    to_wait_ack(12'h010, 8'h5A, 12'd2, 2'd1, 1'b0, hobs);
    tick();
    repeat (4) tick();
    checks++; if ({m_valid, m_dout} !== 2'b11) begin errors++; $display("FAIL gl_bit5: got %b want 11", {m_valid, m_dout}); end
    bus_grant = 1'b0;
    tick();
    checks++; if ({error, tx_done, m_valid, bus_req} !== 4'b1000) begin errors++; $display("FAIL gl_abort: got %b want 1000", {error, tx_done, m_valid, bus_req}); end
    bus_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL gl_no_tx_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_grant_loss_last;
    logic [24:0] hobs;
    slave_ready = 1'b1;
    to_wait_ack(12'h7FF, 8'hA5, 12'd1, 2'd2, 1'b0, hobs);
    tick();
    repeat (7) tick();
    bus_grant = 1'b0;
    tick();
    checks++; if ({tx_done, error, bus_req} !== 3'b100) begin errors++; $display("FAIL gl_last_bit: got %b want 100", {tx_done, error, bus_req}); end
    bus_grant = 1'b1;
  endtask

  task automatic test_reset_mid_read;
    logic [24:0] hobs;
    logic [7:0]  w0, w1, dobs;
    w0 = 8'h44; w1 = 8'h99;
    slave_ready = 1'b1;
    to_wait_ack(12'h055, 8'h00, 12'd3, 2'd2, 1'b1, hobs);
    tick();
    slave_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_din = w0[i];
      tick();
    end
    checks++; if (new_data !== 8'h44) begin errors++; $display("FAIL rst_rd_first_word: got %h want 44", new_data); end
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_din = w1[i];
      tick();
    end
    s_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if ({busy, bus_req, m_valid, slave_select, new_data} !== 13'd0) begin errors++; $display("FAIL rst_async_outputs: got %b want 0", {busy, bus_req, m_valid, slave_select, new_data}); end
    checks++; if ({new_rx, rx_done, tx_done, error} !== 4'b0000) begin errors++; $display("FAIL rst_async_pulses: got %b want 0000", {new_rx, rx_done, tx_done, error}); end
    instruction = 2'b00;
    #3 reset = 1'b1;
    tick();
    slave_ready = 1'b1;
    to_wait_ack(12'h200, 8'h96, 12'd1, 2'd1, 1'b0, hobs);
    checks++; if (hobs !== 25'h0002400) begin errors++; $display("FAIL rst_fresh_header: got %h want 0002400", hobs); end
    tick();
    for (int i = 0; i < 8; i++) begin
      dobs[i] = m_dout;
      tick();
    end
    checks++; if ({tx_done, dobs} !== {1'b1, 8'h96}) begin errors++; $display("FAIL rst_fresh_write: got %b want 110010110", {tx_done, dobs}); end
  endtask

  task automatic test_held_start;
    int done_cnt;
    done_cnt = 0;
    slave_ready = 1'b1; bus_grant = 1'b1;
    instruction = 2'b00;
    tick();
    address = 12'h321; data = 8'h3C; burst_num = 12'd1; slave_select_input = 2'd3;
    instruction = 2'b10;
    for (int c = 1; c <= 50; c++) begin
      if (c == 10) instruction = 2'b00;
      if (c == 11) instruction = 2'b10;
      tick();
      if (tx_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL held_tx_done_count: got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_after: got %b want 0", busy); end
    instruction = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_read();
    test_timeout();
    test_grant_loss();
    test_grant_loss_last();
    test_reset_mid_read();
    test_held_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
